// File: rtl/systolic_sched.sv
// Tile sequencer for the weight-stationary systolic array: weight load, bank switch,
// skewed activation streaming, per-column output valids and tile completion.
module systolic_sched #(
    parameter int SYS_ROWS = 4,
    parameter int SYS_COLS = 4,
    parameter int AW       = 10,
    parameter int NW       = 16,
    parameter int OUT_LAT  = SYS_ROWS + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [NW-1:0]       cmd_nvec,
    input  logic [AW-1:0]       cmd_waddr,
    input  logic [AW-1:0]       cmd_aaddr,
    output logic                w_rd_en,
    output logic [AW-1:0]       w_rd_addr,
    output logic                a_rd_en,
    output logic [AW-1:0]       a_rd_addr,
    output logic [SYS_COLS-1:0] wfetch,
    output logic                switch,
    output logic [SYS_ROWS-1:0] if_en,
    output logic [SYS_COLS-1:0] of_valid,
    output logic                busy,
    output logic                done
);

    localparam int L = OUT_LAT + SYS_COLS - 1;

    typedef enum logic [2:0] {IDLE, WLOAD, WWAIT, SWITCH, STREAM, DRAIN, DONE} state_t;

    state_t        state;
    logic [NW-1:0] cnt;
    logic [NW-1:0] nvec;
    logic [AW-1:0] waddr;
    logic [AW-1:0] aaddr;
    logic [L:1]    dly;
    logic          wf;
    logic          accept;
    logic          drained;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

    // Judged two stages early so that done lands on the first cycle the lines read all-zero.
    assign drained = !a_rd_en && (dly[L-2:1] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nvec      <= '0;
            waddr     <= '0;
            aaddr     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            w_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
            switch    <= 1'b0;
            done      <= 1'b0;
        end else begin
            w_rd_en   <= 1'b0;
            a_rd_en   <= 1'b0;
            switch    <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= (state == IDLE) && !accept;
            busy      <= !((state == IDLE) && !accept);
            case (state)
                IDLE: begin
                    if (accept) begin
                        nvec  <= cmd_nvec;
                        waddr <= cmd_waddr;
                        aaddr <= cmd_aaddr;
                        cnt   <= '0;
                        state <= WLOAD;
                    end
                end
                WLOAD: begin
                    w_rd_en   <= 1'b1;
                    w_rd_addr <= waddr + AW'(cnt);
                    if (cnt == NW'(SYS_ROWS - 1)) begin
                        state <= WWAIT;
                    end else begin
                        cnt <= cnt + NW'(1);
                    end
                end
                WWAIT: state <= SWITCH;
                SWITCH: begin
                    switch <= 1'b1;
                    cnt    <= '0;
                    state  <= (nvec != '0) ? STREAM : DRAIN;
                end
                STREAM: begin
                    a_rd_en   <= 1'b1;
                    a_rd_addr <= aaddr + AW'(cnt);
                    if (cnt == nvec - NW'(1)) begin
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + NW'(1);
                    end
                end
                DRAIN: if (drained) state <= DONE;
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly <= '0;
            wf  <= 1'b0;
        end else begin
            dly <= {dly[L-1:1], a_rd_en};
            wf  <= w_rd_en;
        end
    end

    always_comb begin
        wfetch   = {SYS_COLS{wf}};
        if_en    = '0;
        of_valid = '0;
        for (int unsigned r = 0; r < SYS_ROWS; r++) if_en[r] = dly[r + 1];
        for (int unsigned c = 0; c < SYS_COLS; c++) of_valid[c] = dly[OUT_LAT + c];
    end

endmodule

// File: tb/tb_systolic_sched.sv
// Self-checking bench for systolic_sched: directed and random tiles against a cycle-window model.
module tb_systolic_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_nvec = '0;
    logic [9:0]  cmd_waddr = '0;
    logic [9:0]  cmd_aaddr = '0;
    logic        w_rd_en;
    logic [9:0]  w_rd_addr;
    logic        a_rd_en;
    logic [9:0]  a_rd_addr;
    logic [3:0]  wfetch;
    logic        switch;
    logic [3:0]  if_en;
    logic [3:0]  of_valid;
    logic        busy;
    logic        done;

    systolic_sched #(.SYS_ROWS(4), .SYS_COLS(4), .AW(10), .NW(16), .OUT_LAT(5)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_nvec(cmd_nvec), .cmd_waddr(cmd_waddr), .cmd_aaddr(cmd_aaddr),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .wfetch(wfetch), .switch(switch), .if_en(if_en), .of_valid(of_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int start;
        int n;
        int wa;
        int aa;
    } tile_t;

    tile_t tiles[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    bit    acc_flag;

    // Relative cycle of the done pulse; the last of_valid[3] falls at 14+n.
    function automatic int done_off(input int n);
        return (n == 0) ? 8 : 15 + n;
    endfunction

    function automatic bit model_ready(input int g);
        bit r = 1'b1;
        foreach (tiles[i]) begin
            int k = g - tiles[i].start;
            if (k >= 0 && k <= done_off(tiles[i].n)) r = 1'b0;
        end
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic       er, eb, ew, ea, ewf, esw, edn;
        logic [3:0] eif, eov;
        logic [9:0] ewa, eaa;
        logic [17:0] e, o;
        er = 1'b1; eb = 1'b0; ew = 1'b0; ea = 1'b0; ewf = 1'b0; esw = 1'b0; edn = 1'b0;
        eif = '0; eov = '0; ewa = '0; eaa = '0;
        foreach (tiles[i]) begin
            int k = cyc - tiles[i].start;
            int n = tiles[i].n;
            if (k < 0) continue;
            if (k <= done_off(n)) begin er = 1'b0; eb = 1'b1; end
            if (k >= 1 && k <= 4) begin ew = 1'b1; ewa = 10'((tiles[i].wa + k - 1) & 1023); end
            if (k >= 2 && k <= 5) ewf = 1'b1;
            if (k == 6) esw = 1'b1;
            if (k >= 7 && k <= 6 + n) begin ea = 1'b1; eaa = 10'((tiles[i].aa + k - 7) & 1023); end
            for (int r = 0; r < 4; r++) if (k >= 8 + r && k <= 7 + n + r) eif[r] = 1'b1;
            for (int c = 0; c < 4; c++) if (k >= 12 + c && k <= 11 + n + c) eov[c] = 1'b1;
            if (k == done_off(n)) edn = 1'b1;
        end
        e = {er, eb, ew, ea, {4{ewf}}, esw, eif, eov, edn};
        o = {cmd_ready, busy, w_rd_en, a_rd_en, wfetch, switch, if_en, of_valid, done};
        cmp("outputs", 32'(o), 32'(e));
        if (ew) cmp("w_rd_addr", 32'(w_rd_addr), 32'(ewa));
        if (ea) cmp("a_rd_addr", 32'(a_rd_addr), 32'(eaa));
        cmp("rd_overlap", 32'(w_rd_en & a_rd_en), 32'(0));
        cmp("switch_wfetch_overlap", 32'(switch & wfetch[0]), 32'(0));
    endtask

    task automatic step();
        bit acc = cmd_valid && rst && model_ready(cyc);
        tile_t t;
        @(posedge clk);
        cyc++;
        acc_flag = acc;
        if (acc) begin
            t.start = cyc; t.n = int'(cmd_nvec); t.wa = int'(cmd_waddr); t.aa = int'(cmd_aaddr);
            tiles.push_back(t);
        end
        #1;
        check_cycle();
    endtask

    task automatic idle(input int m);
        for (int i = 0; i < m; i++) step();
    endtask

    task automatic send(input int n, input int wa, input int aa, input bit hold);
        bit got = 1'b0;
        cmd_nvec = 16'(n); cmd_waddr = 10'(wa); cmd_aaddr = 10'(aa); cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = acc_flag;
        end
        cmp("accept_timeout", 32'(got), 32'(1));
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before the next edge.
    task automatic async_reset(input string tag);
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        tiles.delete();
        cmp(tag, 32'({cmd_ready, busy, w_rd_en, a_rd_en, wfetch, switch, if_en, of_valid, done}),
            32'(18'h20000));
        cmp({tag, "_addr"}, 32'({w_rd_addr, a_rd_addr}), 32'(0));
        idle(3);
        rst = 1'b1;
    endtask

    initial begin
        #2;
        async_reset("reset_async");
        idle(3);

        send(8, 'h10, 'h40, 1'b0);
        idle(30);

        send(0, 'h20, 'h50, 1'b0);
        idle(15);

        send(3, 'h100, 'h200, 1'b1);
        send(5, 'h120, 'h220, 1'b0);
        idle(30);

        send(6, 'h3FE, 'h3FC, 1'b0);
        idle(28);

        send(8, 'h10, 'h40, 1'b0);
        idle(10);
        async_reset("reset_abort");
        send(8, 'h10, 'h40, 1'b0);
        idle(30);

        for (int i = 0; i < 8; i++) begin
            bit hold = (i < 7) && ($urandom_range(0, 1) == 1);
            send(int'($urandom_range(0, 10)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 1023)), hold);
            if (!hold) idle(int'($urandom_range(0, 25)));
        end
        cmd_valid = 1'b0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
